// File: rtl/add_share_arbiter_pkg.sv
// Shared constants and helpers for the shared-adder arbiter.
// Optional carry output is selected by the ADD_ARB_CARRY_EN macro in the top.
package add_share_arbiter_pkg;

  localparam int unsigned ARB_DATA_LEN = 32;
  localparam int unsigned ARB_REQ_NUM  = 4;

  // Result slot occupancy; the slot flag itself is the state register.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/add_share_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr, cyclically.
module add_arb_rr_pick
  import add_share_arbiter_pkg::*;
#(
  parameter int unsigned REQ_NUM = ARB_REQ_NUM,
  localparam int unsigned ID_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  // Walk offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if ((i == (int'(rr_ptr) + k) % int'(REQ_NUM)) && req_valid[i]) begin
          grant_idx = ID_W'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/add_share_arbiter.sv
// Time-shares one adder between REQ_NUM requesters with a single registered result slot.
// Define ADD_ARB_CARRY_EN to widen the adder and expose resp_cout.
//   state     | meaning
//   ST_EMPTY  | no result held; any valid request may be granted
//   ST_FULL   | result held in resp_*; new grant only if resp_ready drains it
module add_share_arbiter
  import add_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_LEN = ARB_DATA_LEN,
  parameter int unsigned REQ_NUM  = ARB_REQ_NUM,
  localparam int unsigned ID_W    = $clog2(REQ_NUM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REQ_NUM-1:0]          req_valid,
  output logic [REQ_NUM-1:0]          req_ready,
  input  logic [REQ_NUM*DATA_LEN-1:0] req_op_a,
  input  logic [REQ_NUM*DATA_LEN-1:0] req_op_b,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_LEN-1:0]         resp_sum,
`ifdef ADD_ARB_CARRY_EN
  output logic                        resp_cout,
`endif
  output logic [ID_W-1:0]             resp_id
);

  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_idx;
  logic                any_valid;
  logic                slot_free;
  logic                accept;
  logic [DATA_LEN-1:0] op_a_sel;
  logic [DATA_LEN-1:0] op_b_sel;

  add_arb_rr_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign slot_free = (resp_valid == ST_EMPTY) | resp_ready;
  // Gate with rst_n so no requester sees a grant while the slot is being cleared.
  assign accept    = rst_n & slot_free & any_valid;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (accept && (grant_idx == ID_W'(i))) req_ready[i] = 1'b1;
    end
  end

  always_comb begin
    op_a_sel = '0;
    op_b_sel = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant_idx == ID_W'(i)) begin
        op_a_sel = req_op_a[i*DATA_LEN +: DATA_LEN];
        op_b_sel = req_op_b[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

`ifdef ADD_ARB_CARRY_EN
  logic [DATA_LEN:0] sum_full;
  assign sum_full = {1'b0, op_a_sel} + {1'b0, op_b_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_cout <= 1'b0;
    end else if (accept) begin
      resp_cout <= sum_full[DATA_LEN];
    end
  end
`else
  logic [DATA_LEN-1:0] sum_full;
  assign sum_full = op_a_sel + op_b_sel;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= ST_EMPTY;
      resp_sum   <= '0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      resp_valid <= ST_FULL;
      resp_sum   <= sum_full[DATA_LEN-1:0];
      resp_id    <= grant_idx;
      rr_ptr     <= ID_W'(rr_next(32'(grant_idx), REQ_NUM));
    end else if (resp_ready) begin
      resp_valid <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Scoreboard bench for add_share_arbiter (DATA_LEN=32, REQ_NUM=4), both carry builds.
module tb_add_share_arbiter;

  localparam int DL = 32;
  localparam int RN = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [RN-1:0]  req_valid;
  logic [RN-1:0]  req_ready;
  logic [RN*DL-1:0] req_op_a;
  logic [RN*DL-1:0] req_op_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [DL-1:0]  resp_sum;
  logic [1:0]     resp_id;
  logic           resp_cout_obs;

  add_share_arbiter #(.DATA_LEN(DL), .REQ_NUM(RN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op_a   (req_op_a),
    .req_op_b   (req_op_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
`ifdef ADD_ARB_CARRY_EN
    .resp_cout  (resp_cout_obs),
`endif
    .resp_id    (resp_id)
  );

`ifndef ADD_ARB_CARRY_EN
  assign resp_cout_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [DL-1:0] sum;
    logic [1:0]    id;
    logic          cout;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_valid = 1'b0;
  int   m_ptr   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: checks grant and slot contents each cycle before the edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 64'(resp_valid), 64'(0));
      chk("rst_sum",   64'(resp_sum),   64'(0));
      chk("rst_ready", 64'(req_ready),  64'(0));
      sb.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
    end else begin
      logic [RN-1:0] exp_ready;
      int            exp_g;
      bit            found;
      logic [DL:0]   s;
      exp_t          e;
      exp_ready = '0;
      exp_g     = 0;
      found     = 0;
      if (!m_valid || resp_ready) begin
        for (int k = 0; k < RN; k++) begin
          int idx;
          idx = (m_ptr + k) % RN;
          if (!found && req_valid[idx]) begin
            found = 1;
            exp_g = idx;
          end
        end
      end
      if (found) exp_ready[exp_g] = 1'b1;
      chk("req_ready",  64'(req_ready),  64'(exp_ready));
      chk("resp_valid", 64'(resp_valid), 64'(m_valid));
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'(0), 64'(1));
        end else begin
          chk("resp_sum", 64'(resp_sum), 64'(sb[0].sum));
          chk("resp_id",  64'(resp_id),  64'(sb[0].id));
`ifdef ADD_ARB_CARRY_EN
          chk("resp_cout", 64'(resp_cout_obs), 64'(sb[0].cout));
`endif
          if (resp_ready) void'(sb.pop_front());
        end
      end
      if (req_ready != '0) begin
        for (int i = 0; i < RN; i++) if (req_ready[i]) gq.push_back(i);
      end
      if (found) begin
        s = {1'b0, req_op_a[exp_g*DL +: DL]} + {1'b0, req_op_b[exp_g*DL +: DL]};
        e.sum  = s[DL-1:0];
        e.id   = 2'(exp_g);
        e.cout = s[DL];
        sb.push_back(e);
        m_ptr   = (exp_g + 1) % RN;
        m_valid = 1'b1;
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input logic [DL-1:0] a, input logic [DL-1:0] b);
    req_op_a[r*DL +: DL] = a;
    req_op_b[r*DL +: DL] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 0, 1};
  logic [DL-1:0] held_sum;

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_op_a   = '0;
    req_op_b   = '0;
    resp_ready = 1'b1;
    step(2);
    rst_n = 1'b1;

    // 1: single request
    set_ops(2, 32'd3, 32'd5);
    req_valid = 4'b0100;
    #1 chk("t1_ready", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    chk("t1_valid", 64'(resp_valid), 64'(1));
    chk("t1_sum",   64'(resp_sum),   64'(8));
    chk("t1_id",    64'(resp_id),    64'(2));
    step();

    // 2: round robin from pointer 0
    do_reset();
    gq.delete();
    for (int i = 0; i < RN; i++) set_ops(i, 32'(i * 100), 32'(i + 1));
    req_valid = 4'b1111;
    step(6);
    req_valid = '0;
    chk("t2_count", 64'(gq.size()), 64'(6));
    for (int i = 0; i < 6 && i < gq.size(); i++) chk("t2_order", 64'(gq[i]), 64'(exp_order[i]));
    step();

    // 3: backpressure
    resp_ready = 1'b0;
    set_ops(0, 32'd10, 32'd20);
    req_valid = 4'b0001;
    step();
    chk("t3_sum0", 64'(resp_sum), 64'(30));
    set_ops(0, 32'd100, 32'd1);
    held_sum = resp_sum;
    for (int c = 0; c < 3; c++) begin
      chk("t3_noready", 64'(req_ready), 64'(0));
      chk("t3_hold_sum", 64'(resp_sum), 64'(held_sum));
      chk("t3_hold_id",  64'(resp_id),  64'(0));
      step();
    end
    resp_ready = 1'b1;
    #1 chk("t3_regrant", 64'(req_ready), 64'(4'b0001));
    step();
    chk("t3_sum1", 64'(resp_sum), 64'(101));
    chk("t3_id1",  64'(resp_id),  64'(0));

    // 4: wrap and carry
    set_ops(0, 32'hFFFF_FFFF, 32'h0000_0002);
    step();
    chk("t4_wrap_sum", 64'(resp_sum), 64'(1));
`ifdef ADD_ARB_CARRY_EN
    chk("t4_cout1", 64'(resp_cout_obs), 64'(1));
`endif
    set_ops(0, 32'd1, 32'd1);
    step();
    req_valid = '0;
    chk("t4_sum2", 64'(resp_sum), 64'(2));
`ifdef ADD_ARB_CARRY_EN
    chk("t4_cout0", 64'(resp_cout_obs), 64'(0));
`endif
    step();

    // 5: async reset with a held result
    resp_ready = 1'b0;
    set_ops(2, 32'd7, 32'd7);
    req_valid = 4'b0100;
    step();
    chk("t5_full", 64'(resp_valid), 64'(1));
    req_valid = 4'b1001;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(resp_valid), 64'(0));
    chk("t5_rst_sum",   64'(resp_sum),   64'(0));
    chk("t5_rst_ready", 64'(req_ready),  64'(0));
    step(2);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    #1 chk("t5_grant0", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();

    // 6: fairness under a hog on req1
    for (int p = 0; p < 4; p++) begin
      int  waited;
      bit  got;
      waited = 0;
      got    = 0;
      req_valid = 4'b1010;
      for (int c = 0; c < 8 && !got; c++) begin
        set_ops(1, DL'($urandom), DL'($urandom));
        set_ops(3, DL'($urandom), DL'($urandom));
        #3;
        if (req_ready[3]) got = 1;
        else if (req_ready[1]) waited++;
        step();
      end
      chk("t6_granted", 64'(got), 64'(1));
      chk("t6_wait_le1", 64'(waited <= 1), 64'(1));
      req_valid = 4'b0010;
      step(p + 1);
    end
    req_valid = '0;
    step();

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      resp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < RN; i++) set_ops(i, DL'($urandom), DL'($urandom));
      step();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    step(3);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
